// File: rtl/dfs_pkg.sv
// Shared widths and types for the DFS node stack.
package dfs_pkg;

   localparam int IDX_W = 4;
   localparam int WT_W  = 8;
   localparam int LVL_W = 4;

   // One stack entry: node index, accumulated path weight, tree level.
   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [WT_W-1:0]  wt;
      logic [LVL_W-1:0] lvl;
   } dfs_entry_t;

   // RUN processes requests; HALT freezes the stack until clear or reset.
   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } stk_state_t;

endpackage

// File: rtl/dfs_node_stack_if.sv
// Request/status bundle between the DFS control FSM and the node stack.
interface dfs_node_stack_if
   import dfs_pkg::*;
#(
   parameter int DEPTH = 16
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clear;
   logic             push;
   logic [IDX_W-1:0] push_idx;
   logic [WT_W-1:0]  push_wt;
   logic [LVL_W-1:0] push_lvl;
   logic             pop;
   logic [IDX_W-1:0] top_idx;
   logic [WT_W-1:0]  top_wt;
   logic [LVL_W-1:0] top_lvl;
   logic             top_valid;
   logic             empty;
   logic             full;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] peak;
   logic             overflow;
   logic             underflow;
   logic             halted;

   // The FSM side issues requests and observes status.
   modport master (
      output clear, push, push_idx, push_wt, push_lvl, pop,
      input  top_idx, top_wt, top_lvl, top_valid, empty, full,
             count, peak, overflow, underflow, halted
   );

   // The stack side consumes requests and reports status.
   modport slave (
      input  clear, push, push_idx, push_wt, push_lvl, pop,
      output top_idx, top_wt, top_lvl, top_valid, empty, full,
             count, peak, overflow, underflow, halted
   );

endinterface

// File: rtl/dfs_stack_mem.sv
// Entry storage: one synchronous write port, two asynchronous read ports
// (current top and the entry beneath it) so a pop refreshes top with no bubble.
module dfs_stack_mem
   import dfs_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  dfs_entry_t    i_wdata,
   input  logic [AW-1:0] i_raddr_top,
   input  logic [AW-1:0] i_raddr_nxt,
   output dfs_entry_t    o_rdata_top,
   output dfs_entry_t    o_rdata_nxt
);

   dfs_entry_t r_mem [DEPTH];

   // Write the addressed entry.
   // NOTE: the array has no reset; entries above count are never observed, so clearing them would only cost logic.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_top = r_mem[i_raddr_top];
   assign o_rdata_nxt = r_mem[i_raddr_nxt];

endmodule

// File: rtl/dfs_node_stack.sv
// LIFO node stack for the DFS datapath with registered top entry,
// occupancy/peak tracking and sticky overflow/underflow that halt the stack.
module dfs_node_stack
   import dfs_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   dfs_node_stack_if.slave bus
);

   localparam int               AW      = $clog2(DEPTH);
   localparam int               CNT_W   = AW + 1;
   localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_TWO   = CNT_W'(2);

   stk_state_t       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_count, r_peak, w_count_nxt;
   logic [CNT_W-1:0] w_cnt_m1, w_cnt_m2;
   dfs_entry_t       r_top, w_top_nxt, w_push_ent, w_rd_top, w_rd_nxt;
   logic             r_overflow, r_underflow, r_empty, r_full, r_top_valid;
   logic             w_ovf_set, w_udf_set, w_we;
   logic [AW-1:0]    w_waddr;
   logic             w_is_empty, w_is_full;

   assign w_push_ent = '{idx: bus.push_idx, wt: bus.push_wt, lvl: bus.push_lvl};
   assign w_cnt_m1   = r_count - C_ONE;
   assign w_cnt_m2   = r_count - C_TWO;
   assign w_is_empty = (r_count == '0);
   assign w_is_full  = (r_count == C_DEPTH);

   dfs_stack_mem #(.DEPTH(DEPTH)) u_mem (
      .clk         (clk),
      .i_we        (w_we & rst_n),
      .i_waddr     (w_waddr),
      .i_wdata     (w_push_ent),
      .i_raddr_top (w_cnt_m1[AW-1:0]),
      .i_raddr_nxt (w_cnt_m2[AW-1:0]),
      .o_rdata_top (w_rd_top),
      .o_rdata_nxt (w_rd_nxt)
   );

   // State register: reset and clear both return the stack to RUN.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: any overflow or underflow in RUN halts the stack.
   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      if (bus.clear) begin
         w_state_nxt = RUN;
      end else if (r_state == RUN) begin
         if (bus.push && !bus.pop && w_is_full) begin
            w_state_nxt = HALT;
         end
         if (bus.pop && w_is_empty) begin
            w_state_nxt = HALT;
         end
      end
   end

   // Operation decode: memory write, next count, next top and error sets.
   always_comb begin
      w_we        = 1'b0;
      w_waddr     = r_count[AW-1:0];
      w_count_nxt = r_count;
      w_top_nxt   = r_top;
      w_ovf_set   = 1'b0;
      w_udf_set   = 1'b0;
      if (r_state == RUN && !bus.clear) begin
         unique case ({bus.push, bus.pop})
            2'b10: begin
               if (!w_is_full) begin
                  w_we        = 1'b1;
                  w_count_nxt = r_count + C_ONE;
                  w_top_nxt   = w_push_ent;
               end else begin
                  w_ovf_set   = 1'b1;
               end
            end
            2'b01: begin
               if (!w_is_empty) begin
                  w_count_nxt = w_cnt_m1;
                  w_top_nxt   = (r_count == C_ONE) ? '0 : w_rd_nxt;
               end else begin
                  w_udf_set   = 1'b1;
               end
            end
            2'b11: begin
               // Replace the top in place; on an empty stack the push still lands.
               w_we      = 1'b1;
               w_top_nxt = w_push_ent;
               if (!w_is_empty) begin
                  w_waddr     = w_cnt_m1[AW-1:0];
               end else begin
                  w_waddr     = '0;
                  w_count_nxt = C_ONE;
                  w_udf_set   = 1'b1;
               end
            end
            default: begin
               w_top_nxt = w_is_empty ? '0 : w_rd_top;
            end
         endcase
      end
   end

   // Datapath registers: count, peak, top entry, flags and sticky errors.
   always_ff @(posedge clk) begin
      if (!rst_n || bus.clear) begin
         r_count     <= '0;
         r_peak      <= '0;
         r_top       <= '0;
         r_empty     <= 1'b1;
         r_full      <= 1'b0;
         r_top_valid <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_count     <= w_count_nxt;
         r_peak      <= (w_count_nxt > r_peak) ? w_count_nxt : r_peak;
         r_top       <= w_top_nxt;
         r_empty     <= (w_count_nxt == '0);
         r_full      <= (w_count_nxt == C_DEPTH);
         r_top_valid <= (w_count_nxt != '0);
         r_overflow  <= r_overflow  | w_ovf_set;
         r_underflow <= r_underflow | w_udf_set;
      end
   end

   assign bus.top_idx   = r_top.idx;
   assign bus.top_wt    = r_top.wt;
   assign bus.top_lvl   = r_top.lvl;
   assign bus.top_valid = r_top_valid;
   assign bus.empty     = r_empty;
   assign bus.full      = r_full;
   assign bus.count     = r_count;
   assign bus.peak      = r_peak;
   assign bus.overflow  = r_overflow;
   assign bus.underflow = r_underflow;
   assign bus.halted    = (r_state == HALT);

endmodule

// File: tb/tb_dfs_node_stack.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based LIFO model of the stack.
module tb_dfs_node_stack;
   import dfs_pkg::*;

   localparam int DEPTH = 4;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   int   cyc;

   // Reference model state
   logic [15:0] m_q[$];
   bit          m_ovf, m_udf, m_halt;
   int          m_peak;

   dfs_node_stack_if #(.DEPTH(DEPTH)) bus ();

   dfs_node_stack #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_step(input logic rn, input logic clr, input logic ps,
                             input logic pp, input logic [15:0] e);
      if (!rn || clr) begin
         m_q.delete();
         m_ovf  = 0;
         m_udf  = 0;
         m_halt = 0;
         m_peak = 0;
      end else if (!m_halt) begin
         if (ps && !pp) begin
            if (m_q.size() < DEPTH) m_q.push_back(e);
            else begin m_ovf = 1; m_halt = 1; end
         end else if (pp && !ps) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            else begin m_udf = 1; m_halt = 1; end
         end else if (ps && pp) begin
            if (m_q.size() > 0) m_q[m_q.size()-1] = e;
            else begin m_q.push_back(e); m_udf = 1; m_halt = 1; end
         end
         if (m_q.size() > m_peak) m_peak = m_q.size();
      end
   endtask

   task automatic check_all();
      logic [15:0] exp_top;
      exp_top = (m_q.size() > 0) ? m_q[m_q.size()-1] : 16'h0;
      check("count",     64'(bus.count), 64'(m_q.size()));
      check("top",       64'({bus.top_idx, bus.top_wt, bus.top_lvl}), 64'(exp_top));
      check("top_valid", 64'(bus.top_valid), 64'(m_q.size() > 0));
      check("empty",     64'(bus.empty), 64'(m_q.size() == 0));
      check("full",      64'(bus.full), 64'(m_q.size() == DEPTH));
      check("peak",      64'(bus.peak), 64'(m_peak));
      check("overflow",  64'(bus.overflow), 64'(m_ovf));
      check("underflow", 64'(bus.underflow), 64'(m_udf));
      check("halted",    64'(bus.halted), 64'(m_halt));
   endtask

   // Drive one cycle of inputs, advance the model, check just after the edge.
   task automatic step(input logic rn, input logic clr, input logic ps, input logic pp,
                       input logic [3:0] i, input logic [7:0] w, input logic [3:0] l);
      rst_n        = rn;
      bus.clear    = clr;
      bus.push     = ps;
      bus.pop      = pp;
      bus.push_idx = i;
      bus.push_wt  = w;
      bus.push_lvl = l;
      model_step(rn, clr, ps, pp, {i, w, l});
      @(posedge clk);
      #1;
      cyc++;
      check_all();
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h0, 4'h0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      cyc      = 0;
      m_ovf    = 0;
      m_udf    = 0;
      m_halt   = 0;
      m_peak   = 0;
      #2;

      // Reset state
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h0, 4'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h0, 4'h0);

      // Three pushes, then two pops
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 8'd5,  4'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 8'd9,  4'd1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 8'd12, 4'd2);
      check("plan_peak3", 64'(bus.peak), 64'd3);
      step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 8'd0, 4'd0);
      // count=2, top=(3,9,1): replace the top
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 8'd20, 4'd2);
      check("plan_replace", 64'({bus.top_idx, bus.top_wt, bus.top_lvl}), 64'({4'd4, 8'd20, 4'd2}));
      step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 8'd0, 4'd0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 8'd0, 4'd0);
      idle();

      // Overflow: five pushes into a four-deep stack, then a pop that must be ignored
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 4'd0);
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 4'(k + 8), 8'(k * 17), 4'(k));
      check("plan_ovf", 64'({bus.overflow, bus.halted, bus.count}), 64'({1'b1, 1'b1, 3'd4}));
      step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 8'd0, 4'd0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 4'd0);

      // Underflow: pop on empty after reset
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 4'd0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 8'd0, 4'd0);
      check("plan_udf", 64'({bus.underflow, bus.halted, bus.top_valid}), 64'({1'b1, 1'b1, 1'b0}));
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 4'd0);

      // push+pop on empty
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 8'd3, 4'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 8'd9, 4'd9);
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 4'd0);

      // Reset collides with a push
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 4'(k + 1), 8'(k + 40), 4'(k));
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 8'd255, 4'd15);
      check("plan_rst_push", 64'({bus.count, bus.peak, bus.empty}), 64'({3'd0, 3'd0, 1'b1}));

      // Clear collides with a push
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 8'd6, 4'd7);
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'd6, 8'd7, 4'd8);

      // Random traffic
      for (int k = 0; k < 600; k++) begin
         automatic int  r    = int'($urandom_range(0, 99));
         automatic logic rn  = (r != 0);
         automatic logic clr = (r >= 1 && r <= 4);
         automatic logic ps  = ($urandom_range(0, 99) < 55);
         automatic logic pp  = ($urandom_range(0, 99) < 40);
         step(rn, clr, ps, pp, 4'($urandom), 8'($urandom), 4'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
